// File: rtl/calc_pkg.sv
// Shared types, key codes and the keypad map for the calculator digit path.
package calc_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } kp_state_t;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_EQ  = 4'd13;
   localparam logic [3:0] KEY_CLR = 4'd14;
   localparam logic [3:0] KEY_NEG = 4'd15;

   // Physical keypad layout: row-major, column 0 leftmost.
   function automatic logic [3:0] kp_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] code;
      case ({row_idx, col_idx})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = KEY_ADD;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = KEY_SUB;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = KEY_MUL;
         4'b11_00: code = KEY_CLR;
         4'b11_01: code = 4'd0;
         4'b11_10: code = KEY_NEG;
         default:  code = KEY_EQ;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/calc_sync2.sv
// Two-flop synchroniser; resets to all-ones to match idle pulled-up inputs.
module calc_sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/calc_keypad_encoder.sv
// 4x4 matrix keypad scanner: column scan, debounce and one-pulse-per-press encoding.
module calc_keypad_encoder
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 100_000,
   parameter int unsigned DEBOUNCE_N = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam int unsigned DW = $clog2(DEBOUNCE_N + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_N);

   logic [3:0]    row_s;
   logic [SW-1:0] slot_q, slot_d;
   kp_state_t     state_q, state_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [DW-1:0] deb_q, deb_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_down_q, key_down_d;

   logic          sample;
   logic          row_any;
   logic [1:0]    low_idx;
   logic [DW-1:0] deb_inc;

   calc_sync2 #(.WIDTH(4)) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d_i (row),
      .q_o (row_s)
   );

   assign sample  = (slot_q == SLOT_LAST);
   assign row_any = (row_s != 4'hF);
   assign deb_inc = (deb_q == '1) ? deb_q : deb_q + DW'(1);

   // Lowest-index active-low row wins among simultaneous presses in a column.
   always_comb begin
      low_idx = 2'd3;
      casez (row_s)
         4'b???0: low_idx = 2'd0;
         4'b??01: low_idx = 2'd1;
         4'b?011: low_idx = 2'd2;
         default: low_idx = 2'd3;
      endcase
   end

   // Slot counter: row_s is only looked at on the last count of each column slot.
   always_comb begin
      slot_d = sample ? '0 : slot_q + SW'(1);
   end

   // Scan / debounce / held sequencing; all decisions happen on sample events.
   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      deb_d       = deb_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      if (sample) begin
         case (state_q)
            SCAN: begin
               if (!row_any) begin
                  col_idx_d = col_idx_q + 2'd1;
               end else begin
                  row_idx_d = low_idx;
                  if (DEBOUNCE_N <= 1) begin
                     key_code_d  = kp_map(low_idx, col_idx_q);
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     deb_d       = '0;
                     state_d     = HELD;
                  end else begin
                     deb_d   = DW'(1);
                     state_d = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (!row_any) begin
                  deb_d     = '0;
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = SCAN;
               end else if (low_idx == row_idx_q) begin
                  if (deb_inc >= DEB_MAX) begin
                     key_code_d  = kp_map(low_idx, col_idx_q);
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     deb_d       = '0;
                     state_d     = HELD;
                  end else begin
                     deb_d = deb_inc;
                  end
               end else begin
                  row_idx_d = low_idx;
                  deb_d     = DW'(1);
               end
            end
            HELD: begin
               if (row_any) begin
                  deb_d = '0;
               end else if (deb_inc >= DEB_MAX) begin
                  key_down_d = 1'b0;
                  deb_d      = '0;
                  col_idx_d  = col_idx_q + 2'd1;
                  state_d    = SCAN;
               end else begin
                  deb_d = deb_inc;
               end
            end
            default: begin
               state_d = SCAN;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q      <= '0;
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         deb_q       <= '0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         deb_q       <= deb_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
      end
   end

   // Column drive is a pure decode of the index, so exactly one bit is ever low.
   assign col       = ~(4'b0001 << col_idx_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;

endmodule
